// File: rtl/proc_bypass_pkg.sv
// proc_bypass_pkg: shared entry type and constants for the bypass scoreboard
package proc_bypass_pkg;
  localparam int c_nregs = 32;
  localparam logic [4:0] c_rd_zero = 5'd0;
  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] rd;
    logic       late;
  } sb_entry_t;
  localparam int c_ent_w = $bits(sb_entry_t);
  function automatic logic is_live(sb_entry_t e);
    return e.val & e.wen & (e.rd != c_rd_zero);
  endfunction
endpackage

// File: rtl/proc_bypass_src_sel.sv
// proc_bypass_src_sel: picks the youngest live producer of one source operand
// ports: ent_i entry vector (stage 0 lowest), late_ok_i stages where late results are valid,
//        rs_addr_i/rf_rdata_i source address and rf data, result_i per-stage results,
//        data_o forwarded operand, unready_o youngest match not yet valid,
//        fwd_o (PROC_BYPASS_SCOREBOARD_STATS_EN only) operand taken from a stage
module proc_bypass_src_sel
  import proc_bypass_pkg::*;
#(
  parameter int p_nstages = 3,
  parameter int p_xlen    = 32
) (
  input  logic [c_ent_w*p_nstages-1:0] ent_i,
  input  logic [p_nstages-1:0]         late_ok_i,
  input  logic [4:0]                   rs_addr_i,
  input  logic [p_xlen-1:0]            rf_rdata_i,
  input  logic [p_xlen*p_nstages-1:0]  result_i,
  output logic [p_xlen-1:0]            data_o,
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
  output logic                         fwd_o,
`endif
  output logic                         unready_o
);
  sb_entry_t e;
  logic rdy;
  always_comb begin
    e = '0;
    rdy = 1'b0;
    data_o = rf_rdata_i;
    unready_o = 1'b0;
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
    fwd_o = 1'b0;
`endif
    // walk oldest to youngest so the youngest match overrides
    for (int s = p_nstages - 1; s >= 0; s--) begin
      e = sb_entry_t'(ent_i[s*c_ent_w +: c_ent_w]);
      rdy = ~e.late | late_ok_i[s];
      if (is_live(e) && e.rd == rs_addr_i) begin
        data_o = rdy ? result_i[s*p_xlen +: p_xlen] : rf_rdata_i;
        unready_o = ~rdy;
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
        fwd_o = rdy;
`endif
      end
    end
  end
endmodule

// File: rtl/proc_bypass_scoreboard.sv
// proc_bypass_scoreboard: in-flight write tracker producing forwarded operands and decode stall
// ports: clk, reset (async active-high); issue_*_D decode instruction; squash_D kills it;
//        rs_addr_D/rf_rdata_D per-source address and rf data; stage_en/stage_result per stage;
//        op_data_D forwarded operands; stall_D RAW stall; pending_mask live destination set
// option: PROC_BYPASS_SCOREBOARD_STATS_EN adds stat_stall_cycles and stat_bypass_count
module proc_bypass_scoreboard
  import proc_bypass_pkg::*;
#(
  parameter int p_nstages    = 3,
  parameter int p_nsrcs      = 2,
  parameter int p_xlen       = 32,
  parameter int p_late_stage = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_val_D,
  input  logic                        issue_wen_D,
  input  logic [4:0]                  issue_rd_D,
  input  logic                        issue_late_D,
  input  logic                        squash_D,
  input  logic [5*p_nsrcs-1:0]        rs_addr_D,
  input  logic [p_xlen*p_nsrcs-1:0]   rf_rdata_D,
  input  logic [p_nstages-1:0]        stage_en,
  input  logic [p_xlen*p_nstages-1:0] stage_result,
  output logic [p_xlen*p_nsrcs-1:0]   op_data_D,
  output logic                        stall_D,
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
  output logic [31:0]                 stat_stall_cycles,
  output logic [31:0]                 stat_bypass_count,
`endif
  output logic [c_nregs-1:0]          pending_mask
);
  sb_entry_t [p_nstages-1:0] ent_q, ent_d, in_e;
  logic [p_nstages-1:0] late_ok, adv;
  logic [p_nsrcs-1:0] unready;
  assign stall_D = issue_val_D & ~squash_D & (|unready);
  // the last stage always drains, so an unloaded last entry becomes a bubble
  assign adv = {1'b1, stage_en[p_nstages-1:1]};
  always_comb begin
    late_ok = '0;
    for (int s = 0; s < p_nstages; s++) late_ok[s] = (s >= p_late_stage);
  end
  always_comb begin
    in_e = {ent_q[p_nstages-2:0],
            {issue_val_D & ~stall_D & ~squash_D, issue_wen_D, issue_rd_D, issue_late_D}};
    ent_d = ent_q;
    for (int s = 0; s < p_nstages; s++) begin
      if (stage_en[s]) ent_d[s] = in_e[s];
      else if (adv[s]) ent_d[s].val = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ent_q <= '0;
    else ent_q <= ent_d;
  end
  always_comb begin
    pending_mask = '0;
    for (int s = 0; s < p_nstages; s++) if (is_live(ent_q[s])) pending_mask[ent_q[s].rd] = 1'b1;
  end
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
  logic [p_nsrcs-1:0] fwd;
  logic [31:0] stall_cnt_q, byp_cnt_q, byp_add;
  always_comb begin
    byp_add = '0;
    for (int i = 0; i < p_nsrcs; i++) byp_add = byp_add + 32'(fwd[i]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      byp_cnt_q <= '0;
    end else begin
      if (stall_D) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (issue_val_D & ~stall_D & ~squash_D & stage_en[0]) byp_cnt_q <= byp_cnt_q + byp_add;
    end
  end
  assign stat_stall_cycles = stall_cnt_q;
  assign stat_bypass_count = byp_cnt_q;
`endif
  for (genvar i = 0; i < p_nsrcs; i++) begin : g_src
    proc_bypass_src_sel #(.p_nstages(p_nstages), .p_xlen(p_xlen)) u_sel (
      .ent_i     (ent_q),
      .late_ok_i (late_ok),
      .rs_addr_i (rs_addr_D[5*i +: 5]),
      .rf_rdata_i(rf_rdata_D[p_xlen*i +: p_xlen]),
      .result_i  (stage_result),
      .data_o    (op_data_D[p_xlen*i +: p_xlen]),
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
      .fwd_o     (fwd[i]),
`endif
      .unready_o (unready[i])
    );
  end
endmodule

// File: tb/tb_proc_bypass_scoreboard.sv
// tb_proc_bypass_scoreboard: directed checks of forwarding, stalls, squash, stage enables and reset
module tb_proc_bypass_scoreboard;
  localparam logic [31:0] rf0 = 32'hAAAA0001;
  localparam logic [31:0] rf1 = 32'hBBBB0002;
  logic clk = 1'b0;
  logic reset;
  logic issue_val_D, issue_wen_D, issue_late_D, squash_D;
  logic [4:0] issue_rd_D;
  logic [9:0] rs_addr_D;
  logic [63:0] rf_rdata_D, op_data_D;
  logic [2:0] stage_en;
  logic [95:0] stage_result;
  logic stall_D;
  logic [31:0] pending_mask;
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_bypass_count;
`endif
  int total = 0;
  int bad = 0;
  proc_bypass_scoreboard dut (
    .clk(clk), .reset(reset), .issue_val_D(issue_val_D), .issue_wen_D(issue_wen_D),
    .issue_rd_D(issue_rd_D), .issue_late_D(issue_late_D), .squash_D(squash_D),
    .rs_addr_D(rs_addr_D), .rf_rdata_D(rf_rdata_D), .stage_en(stage_en),
    .stage_result(stage_result), .op_data_D(op_data_D), .stall_D(stall_D),
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
    .stat_stall_cycles(stat_stall_cycles), .stat_bypass_count(stat_bypass_count),
`endif
    .pending_mask(pending_mask)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic w, input logic [4:0] rd, input logic l);
    issue_val_D = v;
    issue_wen_D = w;
    issue_rd_D = rd;
    issue_late_D = l;
  endtask
  task automatic flush;
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    squash_D = 1'b0;
    stage_en = 3'b111;
    rs_addr_D = '0;
    repeat (3) step();
  endtask
  task automatic test_reset;
    reset = 1'b1;
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    squash_D = 1'b0;
    stage_en = 3'b111;
    rs_addr_D = {5'd6, 5'd5};
    rf_rdata_D = {rf1, rf0};
    stage_result = {32'h3, 32'h2, 32'h1};
    #2;
    total++; if (pending_mask !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=%h", pending_mask, 32'h0); end
    total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_D); end
    total++; if (op_data_D !== {rf1, rf0}) begin bad++; $display("FAIL reset_op got=%h exp=%h", op_data_D, {rf1, rf0}); end
    step();
    reset = 1'b0;
    flush();
  endtask
  task automatic test_alu_back_to_back;
    issue(1'b1, 1'b1, 5'd5, 1'b0);
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd5};
    stage_result = {32'h3, 32'h2, 32'h11};
    #1;
    total++; if (op_data_D !== {rf1, 32'h11}) begin bad++; $display("FAIL alu_x_fwd got=%h exp=%h", op_data_D, {rf1, 32'h11}); end
    total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL alu_x_stall got=%b exp=0", stall_D); end
    total++; if (pending_mask !== 32'h20) begin bad++; $display("FAIL alu_mask got=%h exp=%h", pending_mask, 32'h20); end
    step();
    stage_result = {32'h3, 32'h11, 32'h99};
    #1;
    total++; if (op_data_D !== {rf1, 32'h11}) begin bad++; $display("FAIL alu_m_fwd got=%h exp=%h", op_data_D, {rf1, 32'h11}); end
    flush();
  endtask
  task automatic test_load_use;
    issue(1'b1, 1'b1, 5'd6, 1'b1);
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd6};
    stage_result = {32'h3, 32'h2, 32'h55};
    #1;
    total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_D); end
    step();
    stage_result = {32'h3, 32'hDEADBEEF, 32'h55};
    #1;
    total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_D); end
    total++; if (op_data_D !== {rf1, 32'hDEADBEEF}) begin bad++; $display("FAIL lu_fwd got=%h exp=%h", op_data_D, {rf1, 32'hDEADBEEF}); end
    total++; if (pending_mask !== 32'h40) begin bad++; $display("FAIL lu_mask got=%h exp=%h", pending_mask, 32'h40); end
    flush();
  endtask
  task automatic test_priority;
    issue(1'b1, 1'b1, 5'd7, 1'b0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    step();
    issue(1'b1, 1'b1, 5'd7, 1'b0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd7, 5'd7};
    stage_result = {32'h3, 32'h2, 32'h1};
    #1;
    total++; if (op_data_D !== {32'h1, 32'h1}) begin bad++; $display("FAIL prio_young got=%h exp=%h", op_data_D, {32'h1, 32'h1}); end
    flush();
    issue(1'b1, 1'b1, 5'd7, 1'b0);
    step();
    issue(1'b1, 1'b1, 5'd7, 1'b1);
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd7};
    #1;
    total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL prio_mask_stall got=%b exp=1", stall_D); end
    flush();
  endtask
  task automatic test_x0_squash;
    issue(1'b1, 1'b1, 5'd0, 1'b0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd0};
    #1;
    total++; if (pending_mask !== 32'h0) begin bad++; $display("FAIL x0_mask got=%h exp=%h", pending_mask, 32'h0); end
    total++; if (op_data_D !== {rf1, rf0}) begin bad++; $display("FAIL x0_op got=%h exp=%h", op_data_D, {rf1, rf0}); end
    flush();
    issue(1'b1, 1'b1, 5'd6, 1'b1);
    step();
    issue(1'b1, 1'b1, 5'd9, 1'b0);
    rs_addr_D = {5'd0, 5'd6};
    squash_D = 1'b1;
    #1;
    total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL squash_stall got=%b exp=0", stall_D); end
    step();
    squash_D = 1'b0;
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    total++; if (pending_mask !== 32'h40) begin bad++; $display("FAIL squash_bubble got=%h exp=%h", pending_mask, 32'h40); end
    flush();
  endtask
  task automatic test_stall_hold;
    issue(1'b1, 1'b1, 5'd8, 1'b0);
    step();
    issue(1'b1, 1'b1, 5'd9, 1'b0);
    step();
    issue(1'b0, 1'b0, 5'd0, 1'b0);
    stage_en = 3'b100;
    step();
    rs_addr_D = {5'd8, 5'd9};
    stage_result = {32'h3, 32'h2, 32'h1};
    #1;
    total++; if (pending_mask !== 32'h300) begin bad++; $display("FAIL hold_mask got=%h exp=%h", pending_mask, 32'h300); end
    total++; if (op_data_D !== {32'h3, 32'h1}) begin bad++; $display("FAIL hold_fwd got=%h exp=%h", op_data_D, {32'h3, 32'h1}); end
    stage_en = 3'b110;
    step();
    #1;
    total++; if (pending_mask !== 32'h200) begin bad++; $display("FAIL adv_mask got=%h exp=%h", pending_mask, 32'h200); end
    total++; if (op_data_D !== {rf1, 32'h2}) begin bad++; $display("FAIL adv_fwd got=%h exp=%h", op_data_D, {rf1, 32'h2}); end
    flush();
  endtask
  task automatic test_reset_mid;
    issue(1'b1, 1'b1, 5'd6, 1'b1);
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd6};
    #1;
    total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%b exp=1", stall_D); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", stall_D); end
    total++; if (pending_mask !== 32'h0) begin bad++; $display("FAIL mid_mask got=%h exp=%h", pending_mask, 32'h0); end
    total++; if (op_data_D !== {rf1, rf0}) begin bad++; $display("FAIL mid_op got=%h exp=%h", op_data_D, {rf1, rf0}); end
    reset = 1'b0;
    flush();
  endtask
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
  task automatic test_stats;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    issue(1'b1, 1'b1, 5'd5, 1'b0);
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd5, 5'd5};
    step();
    issue(1'b1, 1'b1, 5'd6, 1'b1);
    rs_addr_D = '0;
    step();
    issue(1'b1, 1'b0, 5'd0, 1'b0);
    rs_addr_D = {5'd0, 5'd6};
    stage_en = 3'b000;
    repeat (3) step();
    total++; if (stat_stall_cycles !== 32'd3) begin bad++; $display("FAIL stat_stall got=%0d exp=3", stat_stall_cycles); end
    total++; if (stat_bypass_count !== 32'd2) begin bad++; $display("FAIL stat_bypass got=%0d exp=2", stat_bypass_count); end
    flush();
  endtask
`endif
  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_priority();
    test_x0_squash();
    test_stall_hold();
    test_reset_mid();
`ifdef PROC_BYPASS_SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
